// File: rtl/display_arbiter_pkg.sv
// Shared constants for the tube display arbiter: mode codes, source indices,
// FSM encoding and the mode-to-default-owner map.
package display_arbiter_pkg;

    localparam int CNT_W = 4;

    localparam logic [2:0] STANDBY               = 3'b000;
    localparam logic [2:0] GEAR_LOW              = 3'b001;
    localparam logic [2:0] GEAR_MID              = 3'b010;
    localparam logic [2:0] GEAR_HIGH             = 3'b011;
    localparam logic [2:0] SELF_CLEAN            = 3'b100;
    localparam logic [2:0] ANNOUNCE              = 3'b101;
    localparam logic [2:0] GESTURE               = 3'b110;
    localparam logic [2:0] show_Culmulative_time = 3'b111;

    localparam logic [1:0] SRC_TIME      = 2'd0;
    localparam logic [1:0] SRC_SMOKER    = 2'd1;
    localparam logic [1:0] SRC_SELFCLEAN = 2'd2;
    localparam logic [1:0] SRC_GESTURE   = 2'd3;

    typedef enum logic [1:0] {
        ST_OFF     = 2'd0,
        ST_SHOW    = 2'd1,
        ST_OVERLAY = 2'd2
    } arb_state_e;

    typedef struct packed {
        logic [7:0] digit1;
        logic [7:0] digit2;
        logic [7:0] tube_sel;
    } disp_t;

    function automatic logic [1:0] default_owner(input logic [2:0] mode);
        case (mode)
            GEAR_HIGH, ANNOUNCE, show_Culmulative_time: default_owner = SRC_SMOKER;
            SELF_CLEAN:                                 default_owner = SRC_SELFCLEAN;
            GESTURE:                                    default_owner = SRC_GESTURE;
            default:                                    default_owner = SRC_TIME;
        endcase
    endfunction

endpackage

// File: rtl/display_hold_timer.sv
// Overlay hold timer: loads the hold length, counts tick_1hz strobes down and
// flags the tick that would bring it to zero.
module display_hold_timer
    import display_arbiter_pkg::*;
#(
    parameter int HOLD_SEC = 3
) (
    input  logic clk,
    input  logic rst,
    input  logic i_clr,
    input  logic i_load,
    input  logic i_tick,
    output logic o_zero
);

    logic [CNT_W-1:0] r_cnt;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst)
            r_cnt <= '0;
        else if (i_clr)
            r_cnt <= '0;
        else if (i_load)
            r_cnt <= CNT_W'(HOLD_SEC);
        else if (i_tick && r_cnt != '0)
            r_cnt <= r_cnt - 1'b1;
    end

    // Flag is combinational so the owner can decide on the same edge the count hits zero.
    assign o_zero = i_tick && (r_cnt == CNT_W'(1));

endmodule

// File: rtl/display_arbiter.sv
// Owns the tube display pins: picks the mode-derived owner or a timed overlay,
// blanks the pins across owner changes and registers the selected source.
module display_arbiter
    import display_arbiter_pkg::*;
#(
    parameter int NSRC      = 4,
    parameter int HOLD_SEC  = 3,
    parameter int BLANK_CYC = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              tick_1hz,
    input  logic              machine_state,
    input  logic [2:0]        mode_state,
    input  logic [8*NSRC-1:0] src_digit1,
    input  logic [8*NSRC-1:0] src_digit2,
    input  logic [8*NSRC-1:0] src_tube_sel,
    input  logic [NSRC-1:0]   ovl_req,
    output logic [7:0]        digit1,
    output logic [7:0]        digit2,
    output logic [7:0]        tube_sel,
    output logic [1:0]        owner,
    output logic              overlay_active,
    output logic              ovl_done
);

    localparam logic [CNT_W-1:0] BLANK_LD = (BLANK_CYC > 0) ? CNT_W'(BLANK_CYC - 1) : '0;

    arb_state_e             r_state, w_nxt_state;
    logic [1:0]             r_owner, w_nxt_owner, w_dflt, w_grant;
    logic                   r_ovl_act, r_done;
    logic [CNT_W-1:0]       r_blank;
    disp_t                  r_disp, w_src;
    logic                   w_any_req, w_hi_req, w_load, w_clr, w_tick, w_zero, w_expire, w_chg;
    logic [NSRC-1:0][7:0]   w_d1, w_d2, w_ts;

    assign w_d1      = src_digit1;
    assign w_d2      = src_digit2;
    assign w_ts      = src_tube_sel;
    assign w_dflt    = default_owner(mode_state);
    assign w_any_req = |ovl_req;

    // Fixed priority: lowest index wins.
    always_comb begin
        w_grant = '0;
        for (int i = NSRC - 1; i >= 0; i--)
            if (ovl_req[i]) w_grant = 2'(i);
    end

    always_comb begin
        w_hi_req = 1'b0;
        for (int i = 0; i < NSRC; i++)
            if (ovl_req[i] && 2'(i) < r_owner) w_hi_req = 1'b1;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) r_state <= ST_OFF;
        else      r_state <= w_nxt_state;
    end

    always_comb begin
        w_nxt_state = r_state;
        case (r_state)
            ST_OFF:
                if (machine_state) w_nxt_state = ST_SHOW;
            ST_SHOW:
                if (!machine_state) w_nxt_state = ST_OFF;
                else if (w_any_req) w_nxt_state = ST_OVERLAY;
            ST_OVERLAY:
                if (!machine_state) w_nxt_state = ST_OFF;
                else if (!w_hi_req && w_zero && !ovl_req[r_owner]) w_nxt_state = ST_SHOW;
            default:
                w_nxt_state = ST_OFF;
        endcase
    end

    always_comb begin
        w_nxt_owner = r_owner;
        w_load      = 1'b0;
        w_expire    = 1'b0;
        w_clr       = !machine_state;
        w_tick      = tick_1hz && (r_state == ST_OVERLAY);
        case (r_state)
            ST_OFF:
                w_nxt_owner = machine_state ? w_dflt : 2'd0;
            ST_SHOW:
                if (!machine_state) begin
                    w_nxt_owner = 2'd0;
                end else if (w_any_req) begin
                    w_nxt_owner = w_grant;
                    w_load      = 1'b1;
                end else begin
                    w_nxt_owner = w_dflt;
                end
            ST_OVERLAY:
                if (!machine_state) begin
                    w_nxt_owner = 2'd0;
                end else if (w_hi_req) begin
                    w_nxt_owner = w_grant;
                    w_load      = 1'b1;
                end else if (w_zero) begin
                    // Owner still asserting its request keeps the display for another hold period.
                    if (ovl_req[r_owner]) begin
                        w_load = 1'b1;
                    end else begin
                        w_expire    = 1'b1;
                        w_nxt_owner = w_dflt;
                    end
                end
            default:
                w_nxt_owner = 2'd0;
        endcase
    end

    display_hold_timer #(.HOLD_SEC(HOLD_SEC)) u_hold (
        .clk    (clk),
        .rst    (rst),
        .i_clr  (w_clr),
        .i_load (w_load),
        .i_tick (w_tick),
        .o_zero (w_zero)
    );

    // SHOW<->OVERLAY counts as a change even when the index happens to match.
    assign w_chg = (w_nxt_state != ST_OFF) &&
                   ((w_nxt_state != r_state) || (w_nxt_owner != r_owner));

    assign w_src = '{digit1: w_d1[w_nxt_owner], digit2: w_d2[w_nxt_owner], tube_sel: w_ts[w_nxt_owner]};

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_owner   <= '0;
            r_ovl_act <= 1'b0;
            r_done    <= 1'b0;
            r_blank   <= '0;
            r_disp    <= '0;
        end else begin
            r_owner   <= w_nxt_owner;
            r_ovl_act <= (w_nxt_state == ST_OVERLAY);
            r_done    <= w_expire;
            if (w_nxt_state == ST_OFF) begin
                r_disp  <= '0;
                r_blank <= '0;
            end else if (w_chg) begin
                if (BLANK_CYC != 0) begin
                    r_disp  <= '0;
                    r_blank <= BLANK_LD;
                end else begin
                    r_disp  <= w_src;
                    r_blank <= '0;
                end
            end else if (r_blank != '0) begin
                r_disp  <= '0;
                r_blank <= r_blank - 1'b1;
            end else begin
                r_disp  <= w_src;
            end
        end
    end

    assign digit1         = r_disp.digit1;
    assign digit2         = r_disp.digit2;
    assign tube_sel       = r_disp.tube_sel;
    assign owner          = r_owner;
    assign overlay_active = r_ovl_act;
    assign ovl_done       = r_done;

endmodule

// File: tb/tb_display_arbiter.sv
// Directed-vector bench: stimulus queues expected pin state per cycle, a
// monitor pops and compares one entry after every rising edge.
module tb_display_arbiter;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        tick_1hz = 1'b0;
    logic        machine_state = 1'b0;
    logic [2:0]  mode_state = 3'd0;
    logic [31:0] src_digit1, src_digit2, src_tube_sel;
    logic [3:0]  ovl_req = 4'd0;
    logic [7:0]  digit1, digit2, tube_sel;
    logic [1:0]  owner;
    logic        overlay_active, ovl_done;

    logic [7:0] D1 [4] = '{8'h3F, 8'h06, 8'h5B, 8'h4F};
    logic [7:0] D2 [4] = '{8'h66, 8'h6D, 8'h7D, 8'h07};
    logic [7:0] TS [4] = '{8'h01, 8'h02, 8'h04, 8'h08};

    typedef struct {
        string      lbl;
        logic [1:0] own;
        logic       show;
        logic       ovl;
        logic       done;
    } exp_t;

    exp_t q[$];
    int   n_vec = 0;
    int   n_bad = 0;

    assign src_digit1   = {D1[3], D1[2], D1[1], D1[0]};
    assign src_digit2   = {D2[3], D2[2], D2[1], D2[0]};
    assign src_tube_sel = {TS[3], TS[2], TS[1], TS[0]};

    display_arbiter #(.NSRC(4), .HOLD_SEC(3), .BLANK_CYC(2)) dut (
        .clk            (clk),
        .rst            (rst),
        .tick_1hz       (tick_1hz),
        .machine_state  (machine_state),
        .mode_state     (mode_state),
        .src_digit1     (src_digit1),
        .src_digit2     (src_digit2),
        .src_tube_sel   (src_tube_sel),
        .ovl_req        (ovl_req),
        .digit1         (digit1),
        .digit2         (digit2),
        .tube_sel       (tube_sel),
        .owner          (owner),
        .overlay_active (overlay_active),
        .ovl_done       (ovl_done)
    );

    always #5 clk = ~clk;

    // Monitor: one expected entry per rising edge, sampled 1 time unit after it.
    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (q.size() != 0) begin
                exp_t e;
                logic [7:0] xd1, xd2, xts;
                e   = q.pop_front();
                xd1 = e.show ? D1[e.own] : 8'h00;
                xd2 = e.show ? D2[e.own] : 8'h00;
                xts = e.show ? TS[e.own] : 8'h00;
                n_vec++;
                if ({digit1, digit2, tube_sel, owner, overlay_active, ovl_done} !==
                    {xd1, xd2, xts, e.own, e.ovl, e.done}) begin
                    n_bad++;
                    $display("FAIL %s: got d1=%h d2=%h ts=%h own=%0d ovl=%b done=%b, want d1=%h d2=%h ts=%h own=%0d ovl=%b done=%b",
                             e.lbl, digit1, digit2, tube_sel, owner, overlay_active, ovl_done,
                             xd1, xd2, xts, e.own, e.ovl, e.done);
                end
            end
        end
    end

    task automatic cyc(input logic ms, input logic [2:0] md, input logic [3:0] rq, input logic tk,
                       input logic [1:0] eo, input logic es, input logic ea, input logic ed,
                       input string l);
        exp_t e;
        machine_state = ms;
        mode_state    = md;
        ovl_req       = rq;
        tick_1hz      = tk;
        e.lbl = l; e.own = eo; e.show = es; e.ovl = ea; e.done = ed;
        q.push_back(e);
        @(posedge clk);
        #2;
    endtask

    task automatic chk_zero(input string l);
        n_vec++;
        if ({digit1, digit2, tube_sel, owner, overlay_active, ovl_done} !== 29'd0) begin
            n_bad++;
            $display("FAIL %s: got d1=%h d2=%h ts=%h own=%0d ovl=%b done=%b, want all zero",
                     l, digit1, digit2, tube_sel, owner, overlay_active, ovl_done);
        end
    endtask

    initial begin
        #1 rst = 1'b0;
        #2 chk_zero("reset_state");
        #9 rst = 1'b1;
        @(posedge clk);
        #2;
        //  ms md rq    tk  own shw ovl done
        cyc(0, 0, 4'h0, 0,  0, 0, 0, 0, "off_idle");
        cyc(1, 0, 4'h0, 0,  0, 0, 0, 0, "pwr_blank0");
        cyc(1, 0, 4'h0, 0,  0, 0, 0, 0, "pwr_blank1");
        cyc(1, 0, 4'h0, 0,  0, 1, 0, 0, "pwr_src0");
        cyc(1, 1, 4'h0, 0,  0, 1, 0, 0, "gear1_src0");
        cyc(1, 3, 4'h0, 0,  1, 0, 0, 0, "m3_blank0");
        cyc(1, 3, 4'h0, 0,  1, 0, 0, 0, "m3_blank1");
        cyc(1, 3, 4'h0, 0,  1, 1, 0, 0, "m3_src1");
        cyc(1, 0, 4'h0, 0,  0, 0, 0, 0, "m0_blank0");
        cyc(1, 0, 4'h0, 0,  0, 0, 0, 0, "m0_blank1");
        cyc(1, 0, 4'h0, 0,  0, 1, 0, 0, "m0_src0");
        // single-cycle overlay request from selfclean
        cyc(1, 0, 4'h4, 0,  2, 0, 1, 0, "ovl2_enter");
        cyc(1, 0, 4'h0, 0,  2, 0, 1, 0, "ovl2_blank1");
        cyc(1, 0, 4'h0, 0,  2, 1, 1, 0, "ovl2_src");
        cyc(1, 0, 4'h0, 1,  2, 1, 1, 0, "ovl2_t1");
        cyc(1, 0, 4'h0, 0,  2, 1, 1, 0, "ovl2_idle");
        cyc(1, 0, 4'h0, 1,  2, 1, 1, 0, "ovl2_t2");
        cyc(1, 0, 4'h0, 1,  0, 0, 0, 1, "ovl2_expire");
        cyc(1, 0, 4'h0, 0,  0, 0, 0, 0, "exit_blank1");
        cyc(1, 0, 4'h0, 0,  0, 1, 0, 0, "exit_src0");
        // held request: entry-cycle tick ignored, reload at each would-be expiry
        cyc(1, 0, 4'h4, 1,  2, 0, 1, 0, "hold_enter_tick");
        cyc(1, 0, 4'h4, 1,  2, 0, 1, 0, "hold_t1");
        cyc(1, 0, 4'h4, 1,  2, 1, 1, 0, "hold_t2");
        cyc(1, 0, 4'h4, 1,  2, 1, 1, 0, "hold_reload1");
        cyc(1, 0, 4'h4, 1,  2, 1, 1, 0, "hold_t4");
        cyc(1, 0, 4'h4, 1,  2, 1, 1, 0, "hold_t5");
        cyc(1, 0, 4'h4, 1,  2, 1, 1, 0, "hold_reload2");
        cyc(1, 0, 4'h0, 0,  2, 1, 1, 0, "hold_past6");
        cyc(1, 0, 4'h0, 1,  2, 1, 1, 0, "rel_t1");
        cyc(1, 0, 4'h0, 1,  2, 1, 1, 0, "rel_t2");
        cyc(1, 0, 4'h0, 1,  0, 0, 0, 1, "rel_expire");
        cyc(1, 0, 4'h0, 0,  0, 0, 0, 0, "rel_blank1");
        cyc(1, 0, 4'h0, 0,  0, 1, 0, 0, "rel_src0");
        // gesture overlay, pending mode change, smoker preempts
        cyc(1, 0, 4'h8, 0,  3, 0, 1, 0, "g3_enter");
        cyc(1, 0, 4'h8, 1,  3, 0, 1, 0, "g3_t1");
        cyc(1, 4, 4'h0, 0,  3, 1, 1, 0, "g3_mode_pend");
        cyc(1, 4, 4'h2, 0,  1, 0, 1, 0, "pre1_enter");
        cyc(1, 4, 4'h0, 1,  1, 0, 1, 0, "pre1_t1");
        cyc(1, 4, 4'h4, 1,  1, 1, 1, 0, "pre1_lowign");
        cyc(1, 4, 4'h0, 1,  2, 0, 0, 1, "pre1_expire");
        cyc(1, 4, 4'h0, 0,  2, 0, 0, 0, "dflt2_blank1");
        cyc(1, 4, 4'h0, 0,  2, 1, 0, 0, "dflt2_src");
        // power drop mid-overlay
        cyc(1, 0, 4'h1, 0,  0, 0, 1, 0, "off_ovl_enter");
        cyc(1, 0, 4'h0, 0,  0, 0, 1, 0, "off_ovl_blank1");
        cyc(1, 0, 4'h0, 1,  0, 1, 1, 0, "off_ovl_t1");
        cyc(0, 0, 4'h0, 1,  0, 0, 0, 0, "pwr_drop");
        cyc(0, 0, 4'h0, 0,  0, 0, 0, 0, "off_hold");
        cyc(1, 6, 4'h0, 0,  3, 0, 0, 0, "repwr_blank0");
        cyc(1, 6, 4'h0, 1,  3, 0, 0, 0, "repwr_blank1");
        cyc(1, 6, 4'h0, 1,  3, 1, 0, 0, "repwr_src3");
        cyc(1, 6, 4'h0, 1,  3, 1, 0, 0, "show_tick_nodone");
        // asynchronous reset between edges
        #1 rst = 1'b0;
        #1 chk_zero("async_reset");
        #10 rst = 1'b1;
        repeat (2) @(posedge clk);
        #2;
        n_vec++;
        if (q.size() != 0) begin
            n_bad++;
            $display("FAIL queue_drain: got %0d entries left, want 0", q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
